// File: rtl/sram_pkg.sv
// Shared types and SRAM geometry for the burst sequencer.
package sram_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_DRAIN,
        S_DONE
    } sram_burst_state_t;

    localparam int SRAM_ADDR_W       = 18;
    localparam int SRAM_DATA_W       = 16;
    localparam int SRAM_READ_LATENCY = 3;

endpackage

// File: rtl/sram_burst_engine_tag_pipe.sv
// Shift register of read-issue tags; a tag emerges DEPTH cycles after it enters.
module latency_tag_pipe #(
    parameter int DEPTH = 3
) (
    input  logic Clock_50,
    input  logic Reset,
    input  logic tag_in,
    output logic tag_out,
    output logic empty
);

    logic [DEPTH-1:0] tag_p;

    always_ff @(posedge Clock_50) begin
        if (Reset) begin
            tag_p <= '0;
        end else begin
            tag_p[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) begin
                tag_p[i] <= tag_p[i-1];
            end
        end
    end

    assign tag_out = tag_p[DEPTH-1];

    // Empty means nothing is left to emerge after the current cycle, so the
    // drain can retire in the same cycle the final tag is presented.
    always_comb begin
        empty = !tag_in;
        for (int i = 0; i < DEPTH - 1; i++) begin
            if (tag_p[i]) empty = 1'b0;
        end
    end

endmodule

// File: rtl/sram_burst_engine.sv
// Burst sequencer: one command becomes back-to-back single-word SRAM accesses,
// with read data returned as a valid-tagged stream after the fixed latency.
import sram_pkg::*;

module sram_burst_engine #(
    parameter int ADDR_W       = SRAM_ADDR_W,
    parameter int DATA_W       = SRAM_DATA_W,
    parameter int LEN_W        = 18,
    parameter int READ_LATENCY = SRAM_READ_LATENCY
) (
    input  logic              Clock_50,
    input  logic              Reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              busy,
    output logic              done,
    input  logic              SRAM_ready,
    output logic [ADDR_W-1:0] SRAM_address,
    output logic [DATA_W-1:0] SRAM_write_data,
    output logic              SRAM_we_n,
    input  logic [DATA_W-1:0] SRAM_read_data
);

    sram_burst_state_t state, state_n;

    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  remain_q;
    logic              accept;
    logic              issue_rd;
    logic              issue_wr;
    logic              issue_vld_p0;
    logic              pipe_empty;
    logic              last_word;

    assign last_word = (remain_q == LEN_W'(1));

    always_ff @(posedge Clock_50) begin
        if (Reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n  = state;
        accept   = 1'b0;
        issue_rd = 1'b0;
        issue_wr = 1'b0;
        case (state)
            S_IDLE: begin
                if (cmd_valid && SRAM_ready) begin
                    accept = 1'b1;
                    if (cmd_len == '0)  state_n = S_DONE;
                    else if (cmd_write) state_n = S_WRITE;
                    else                state_n = S_READ;
                end
            end
            S_READ: begin
                if (SRAM_ready) begin
                    issue_rd = 1'b1;
                    if (last_word) state_n = S_DRAIN;
                end
            end
            S_WRITE: begin
                if (wr_valid && SRAM_ready) begin
                    issue_wr = 1'b1;
                    if (last_word) state_n = S_DONE;
                end
            end
            S_DRAIN: begin
                if (pipe_empty) state_n = S_DONE;
            end
            S_DONE: state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Issue stage: address/data/we_n registered toward the controller, and the
    // read tag registered alongside so it lines up with the address edge.
    always_ff @(posedge Clock_50) begin
        if (Reset) begin
            addr_q          <= '0;
            remain_q        <= '0;
            SRAM_address    <= '0;
            SRAM_write_data <= '0;
            SRAM_we_n       <= 1'b1;
            issue_vld_p0    <= 1'b0;
        end else begin
            issue_vld_p0 <= issue_rd;
            SRAM_we_n    <= !issue_wr;
            if (accept) begin
                addr_q   <= cmd_addr;
                remain_q <= cmd_len;
            end
            if (issue_rd || issue_wr) begin
                SRAM_address <= addr_q;
                addr_q       <= addr_q + ADDR_W'(1);
                remain_q     <= remain_q - LEN_W'(1);
            end
            if (issue_wr) begin
                SRAM_write_data <= wr_data;
            end
        end
    end

    // Return stage: tag pipe output marks the cycle the controller's data is valid.
    latency_tag_pipe #(
        .DEPTH (READ_LATENCY)
    ) u_tag_pipe (
        .Clock_50 (Clock_50),
        .Reset    (Reset),
        .tag_in   (issue_vld_p0),
        .tag_out  (rd_valid),
        .empty    (pipe_empty)
    );

    assign rd_data   = SRAM_read_data;
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign cmd_ready = !Reset && (state == S_IDLE) && SRAM_ready;
    assign wr_ready  = !Reset && (state == S_WRITE) && SRAM_ready;

endmodule

// File: tb/tb_sram_burst_engine.sv
// Directed bench for sram_burst_engine with a 3-cycle-latency SRAM model.
module tb_sram_burst_engine;

    logic        Clock_50;
    logic        Reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [17:0] cmd_addr;
    logic [17:0] cmd_len;
    logic [15:0] wr_data;
    logic        wr_valid;
    logic        wr_ready;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        busy;
    logic        done;
    logic        SRAM_ready;
    logic [17:0] SRAM_address;
    logic [15:0] SRAM_write_data;
    logic        SRAM_we_n;
    logic [15:0] SRAM_read_data;

    sram_burst_engine dut (
        .Clock_50        (Clock_50),
        .Reset           (Reset),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_write       (cmd_write),
        .cmd_addr        (cmd_addr),
        .cmd_len         (cmd_len),
        .wr_data         (wr_data),
        .wr_valid        (wr_valid),
        .wr_ready        (wr_ready),
        .rd_data         (rd_data),
        .rd_valid        (rd_valid),
        .busy            (busy),
        .done            (done),
        .SRAM_ready      (SRAM_ready),
        .SRAM_address    (SRAM_address),
        .SRAM_write_data (SRAM_write_data),
        .SRAM_we_n       (SRAM_we_n),
        .SRAM_read_data  (SRAM_read_data)
    );

    initial Clock_50 = 1'b0;
    always #10 Clock_50 = ~Clock_50;

    // SRAM behavioural model: registered write, 3-stage read return
    logic [15:0] mem [0:262143];
    logic [15:0] rpipe0, rpipe1, rpipe2;
    logic        pre_we;
    logic [17:0] pre_addr;
    logic [15:0] pre_data;

    always @(posedge Clock_50) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (!SRAM_we_n) mem[SRAM_address] <= SRAM_write_data;
        rpipe0 <= mem[SRAM_address];
        rpipe1 <= rpipe0;
        rpipe2 <= rpipe1;
    end
    assign SRAM_read_data = rpipe2;

    // Event logs, sampled on the falling edge
    int          cyc = 0;
    int          rd_cnt = 0, wr_cnt = 0, ac_cnt = 0, done_cnt = 0, done_cyc = 0;
    logic [15:0] rd_log [0:1023];
    int          rd_cyc [0:1023];
    logic [17:0] wa_log [0:1023];
    logic [15:0] wd_log [0:1023];
    logic [17:0] ac_addr [0:1023];
    int          ac_cyc [0:1023];
    logic [17:0] prev_addr = '0;

    always @(negedge Clock_50) begin
        cyc <= cyc + 1;
        if (rd_valid) begin
            rd_log[rd_cnt] <= rd_data;
            rd_cyc[rd_cnt] <= cyc;
            rd_cnt <= rd_cnt + 1;
        end
        if (!SRAM_we_n) begin
            wa_log[wr_cnt] <= SRAM_address;
            wd_log[wr_cnt] <= SRAM_write_data;
            wr_cnt <= wr_cnt + 1;
        end
        if (SRAM_address != prev_addr) begin
            ac_addr[ac_cnt] <= SRAM_address;
            ac_cyc[ac_cnt]  <= cyc;
            ac_cnt <= ac_cnt + 1;
        end
        prev_addr <= SRAM_address;
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge Clock_50);
        #1;
    endtask

    task automatic preload(input logic [17:0] a, input logic [15:0] d);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        step(1);
        pre_we = 1'b0;
    endtask

    task automatic send_cmd(input logic wr, input logic [17:0] a, input logic [17:0] len);
        bit ok = 0;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_len = len;
        for (int t = 0; t < 50 && !ok; t++) begin
            if (cmd_ready) ok = 1;
            step(1);
        end
        cmd_valid = 1'b0;
        if (!ok) chk("cmd_accept_timeout", 0, 1);
    endtask

    task automatic wait_done(input int d0);
        int t = 0;
        while (done_cnt <= d0 && t < 200) begin
            step(1);
            t++;
        end
        if (done_cnt <= d0) chk("done_timeout", 0, 1);
        step(2);
    endtask

    int r0, w0, a0, d0, ca;
    logic [15:0] bdat [0:2];

    initial begin
        Reset = 1'b1; cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_len = '0;
        wr_data = '0; wr_valid = 0; SRAM_ready = 1'b1; pre_we = 0; pre_addr = '0; pre_data = '0;
        step(3);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_we_n", SRAM_we_n, 1);
        chk("rst_addr", SRAM_address, 0);
        chk("rst_wdata", SRAM_write_data, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_wr_ready", wr_ready, 0);
        chk("rst_cmd_ready", cmd_ready, 0);
        Reset = 1'b0;
        step(1);

        // Test 1: read 100..103
        for (int i = 0; i < 4; i++) preload(18'd100 + 18'(i), 16'hA000 + 16'(i));
        r0 = rd_cnt; a0 = ac_cnt; d0 = done_cnt;
        send_cmd(1'b0, 18'd100, 18'd4);
        wait_done(d0);
        chk("t1_rd_count", rd_cnt - r0, 4);
        for (int i = 0; i < 4; i++) chk($sformatf("t1_rd_data%0d", i), rd_log[r0+i], 16'hA000 + 16'(i));
        chk("t1_consecutive", rd_cyc[r0+3] - rd_cyc[r0], 3);
        ca = -1000;
        for (int i = a0; i < ac_cnt; i++) if (ca == -1000 && ac_addr[i] == 18'd100) ca = ac_cyc[i];
        chk("t1_latency", rd_cyc[r0] - ca, 3);
        chk("t1_done_after_last", done_cyc - rd_cyc[r0+3], 1);
        chk("t1_done_once", done_cnt - d0, 1);

        // Test 2: write 200..202 with wr_valid toggling
        bdat[0] = 16'hB000; bdat[1] = 16'hB111; bdat[2] = 16'hB222;
        w0 = wr_cnt; d0 = done_cnt;
        send_cmd(1'b1, 18'd200, 18'd3);
        for (int i = 0; i < 5; i++) begin
            wr_valid = (i % 2 == 0);
            wr_data  = (i % 2 == 0) ? bdat[i/2] : 16'hDEAD;
            step(1);
        end
        wr_valid = 1'b0;
        wait_done(d0);
        chk("t2_wr_count", wr_cnt - w0, 3);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("t2_wr_addr%0d", i), wa_log[w0+i], 18'd200 + 18'(i));
            chk($sformatf("t2_wr_data%0d", i), wd_log[w0+i], bdat[i]);
        end
        chk("t2_done_once", done_cnt - d0, 1);
        r0 = rd_cnt; d0 = done_cnt;
        send_cmd(1'b0, 18'd200, 18'd3);
        wait_done(d0);
        chk("t2_rb_count", rd_cnt - r0, 3);
        for (int i = 0; i < 3; i++) chk($sformatf("t2_rb_data%0d", i), rd_log[r0+i], bdat[i]);

        // Test 3: read across the address wrap
        preload(18'h3FFFE, 16'hC000); preload(18'h3FFFF, 16'hC001);
        preload(18'h00000, 16'hC002); preload(18'h00001, 16'hC003);
        r0 = rd_cnt; a0 = ac_cnt; d0 = done_cnt;
        send_cmd(1'b0, 18'h3FFFE, 18'd4);
        wait_done(d0);
        chk("t3_addr_changes", ac_cnt - a0, 4);
        chk("t3_addr0", ac_addr[a0],   18'h3FFFE);
        chk("t3_addr1", ac_addr[a0+1], 18'h3FFFF);
        chk("t3_addr2", ac_addr[a0+2], 18'h00000);
        chk("t3_addr3", ac_addr[a0+3], 18'h00001);
        chk("t3_rd_count", rd_cnt - r0, 4);
        for (int i = 0; i < 4; i++) chk($sformatf("t3_rd_data%0d", i), rd_log[r0+i], 16'hC000 + 16'(i));

        // Test 4: empty burst
        r0 = rd_cnt; w0 = wr_cnt; d0 = done_cnt;
        send_cmd(1'b1, 18'd50, 18'd0);
        chk("t4_done_next", done, 1);
        chk("t4_we_n", SRAM_we_n, 1);
        step(1);
        chk("t4_done_pulse", done, 0);
        step(3);
        chk("t4_no_write", wr_cnt - w0, 0);
        chk("t4_no_read", rd_cnt - r0, 0);
        chk("t4_done_once", done_cnt - d0, 1);

        // Test 5: read len 8 with a 2-cycle controller stall and a competing command
        for (int i = 0; i < 8; i++) preload(18'd300 + 18'(i), 16'hD000 + 16'(i));
        r0 = rd_cnt; w0 = wr_cnt; d0 = done_cnt;
        send_cmd(1'b0, 18'd300, 18'd8);
        step(3);
        SRAM_ready = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 18'd500; cmd_len = 18'd1;
        chk("t5_stall_cmd_ready", cmd_ready, 0);
        step(2);
        SRAM_ready = 1'b1;
        chk("t5_busy_cmd_ready", cmd_ready, 0);
        step(1);
        cmd_valid = 1'b0;
        wait_done(d0);
        chk("t5_rd_count", rd_cnt - r0, 8);
        for (int i = 0; i < 8; i++) chk($sformatf("t5_rd_data%0d", i), rd_log[r0+i], 16'hD000 + 16'(i));
        chk("t5_cmd_ignored", wr_cnt - w0, 0);
        chk("t5_done_once", done_cnt - d0, 1);

        // Test 6: reset in the middle of a read burst
        preload(18'd400, 16'hE000); preload(18'd401, 16'hE001);
        r0 = rd_cnt;
        send_cmd(1'b0, 18'd400, 18'd8);
        step(2);
        Reset = 1'b1;
        step(1);
        chk("t6_busy", busy, 0);
        chk("t6_we_n", SRAM_we_n, 1);
        chk("t6_addr", SRAM_address, 0);
        chk("t6_cmd_ready", cmd_ready, 0);
        Reset = 1'b0;
        step(8);
        chk("t6_no_stale_rd", rd_cnt - r0, 0);
        r0 = rd_cnt; d0 = done_cnt;
        send_cmd(1'b0, 18'd400, 18'd2);
        wait_done(d0);
        chk("t6_new_count", rd_cnt - r0, 2);
        chk("t6_new_data0", rd_log[r0],   16'hE000);
        chk("t6_new_data1", rd_log[r0+1], 16'hE001);
        chk("t6_idle", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
